// File: rtl/linebuffer_pingpong.sv
// Double-banked sprite line buffer: render bank fills from the sprite pipe, display bank drains to the mixer.
// Optional read-and-clear of displayed pixels is enabled by defining LINEBUFFER_AUTOCLEAR_EN.
module linebuffer_pingpong #(
  parameter int DEPTH  = 192,
  parameter int ADDR_W = 8,
  parameter int PIX_W  = 4,
  parameter int PAL_W  = 8,
  parameter int DATA_W = PAL_W + PIX_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_swap,
  input  logic              i_pal_load,
  input  logic [PAL_W-1:0]  i_spr_pal,
  input  logic              i_wr_load,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic              i_wr_en,
  input  logic [PIX_W-1:0]  i_color_index,
  input  logic              i_rd_load,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_rd_en,
  input  logic              i_clear_all,
  output logic              o_busy,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_bank_sel
);

  localparam logic [DATA_W-1:0] BACKDROP  = '1;
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t            r_state;
  logic              r_bank_sel;
  logic [PAL_W-1:0]  r_pal;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic [ADDR_W-1:0] r_clr_addr;
  logic              r_clr_bank;
  logic              r_busy;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  logic [DATA_W-1:0] r_mem0 [DEPTH];
  logic [DATA_W-1:0] r_mem1 [DEPTH];

  logic              w_wr_in_range;
  logic              w_rd_in_range;
  logic              w_wr_fire;
  logic              w_sw_fire;
  logic              w_rd_ok;
  logic              w_ac_fire;
  logic              w_ac_bank;
  logic [ADDR_W-1:0] w_ac_addr;
  logic              w_rd_bypass;
  logic [DATA_W-1:0] w_rd_word;
  logic              w_we [2];
  logic [ADDR_W-1:0] w_wa [2];
  logic [DATA_W-1:0] w_wd [2];

  assign w_wr_in_range = {1'b0, r_wr_cnt} < DEPTH_EXT;
  assign w_rd_in_range = {1'b0, r_rd_cnt} < DEPTH_EXT;
  assign w_wr_fire     = i_wr_en & (i_color_index != '0) & w_wr_in_range & ~i_reset;
  assign w_sw_fire     = (r_state == S_SWEEP) & ~i_reset;
  assign w_rd_ok       = i_rd_en & (r_state == S_IDLE);

`ifdef LINEBUFFER_AUTOCLEAR_EN
  logic              r_ac_pend;
  logic              r_ac_bank;
  logic [ADDR_W-1:0] r_ac_addr;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_ac_pend <= 1'b0;
      r_ac_bank <= 1'b0;
      r_ac_addr <= '0;
    end else begin
      r_ac_pend <= w_rd_ok & w_rd_in_range;
      r_ac_bank <= ~r_bank_sel;
      r_ac_addr <= r_rd_cnt;
    end
  end

  assign w_ac_fire = r_ac_pend & ~i_reset;
  assign w_ac_bank = r_ac_bank;
  assign w_ac_addr = r_ac_addr;
`else
  assign w_ac_fire = 1'b0;
  assign w_ac_bank = 1'b0;
  assign w_ac_addr = '0;
`endif

  // One write port per bank: render pixel, then sweep, then read-back clear.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      w_we[b] = 1'b0;
      w_wa[b] = '0;
      w_wd[b] = BACKDROP;
      if (w_wr_fire && (r_bank_sel == 1'(b))) begin
        w_we[b] = 1'b1;
        w_wa[b] = r_wr_cnt;
        w_wd[b] = {r_pal, i_color_index};
      end else if (w_sw_fire && (r_clr_bank == 1'(b))) begin
        w_we[b] = 1'b1;
        w_wa[b] = r_clr_addr;
      end else if (w_ac_fire && (w_ac_bank == 1'(b))) begin
        w_we[b] = 1'b1;
        w_wa[b] = w_ac_addr;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_we[0]) r_mem0[w_wa[0]] <= w_wd[0];
    if (w_we[1]) r_mem1[w_wa[1]] <= w_wd[1];
  end

  // A clear still queued for this very word must win over the stale array contents.
  assign w_rd_bypass = w_ac_fire & (w_ac_bank == ~r_bank_sel) & (w_ac_addr == r_rd_cnt);

  always_comb begin
    w_rd_word = BACKDROP;
    if (w_rd_in_range && !w_rd_bypass)
      w_rd_word = r_bank_sel ? r_mem0[r_rd_cnt] : r_mem1[r_rd_cnt];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_bank_sel <= 1'b0;
      r_pal      <= '0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_clr_addr <= '0;
      r_clr_bank <= 1'b0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= BACKDROP;
    end else begin
      if (i_swap)
        r_bank_sel <= ~r_bank_sel;
      if (i_pal_load)
        r_pal <= i_spr_pal;

      if (i_wr_load)
        r_wr_cnt <= i_wr_addr;
      else if (i_wr_en)
        r_wr_cnt <= r_wr_cnt + 1'b1;

      r_rd_valid <= w_rd_ok;
      if (w_rd_ok)
        r_rd_data <= w_rd_word;
      if (i_rd_load)
        r_rd_cnt <= i_rd_addr;
      else if (w_rd_ok)
        r_rd_cnt <= r_rd_cnt + 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_clear_all) begin
            r_state    <= S_SWEEP;
            r_busy     <= 1'b1;
            r_clr_addr <= '0;
            r_clr_bank <= ~r_bank_sel;
          end
        end
        S_SWEEP: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy     = r_busy;
  assign o_rd_valid = r_rd_valid;
  assign o_rd_data  = r_rd_data;
  assign o_bank_sel = r_bank_sel;

endmodule
